// File: rtl/kws_event_reporter.sv
// Keyword-spotting event reporter: confirms repeated one-hot detections,
// applies a post-event holdoff, and queues timestamped events for the host.
module kws_event_reporter #(
    parameter int NUM_KEYWORDS   = 10,
    parameter int CONFIRM_COUNT  = 3,
    parameter int HOLDOFF_CYCLES = 1024,
    parameter int TS_BITS        = 16,
    parameter int FIFO_DEPTH     = 4,
    localparam int KW_W = (NUM_KEYWORDS > 1) ? $clog2(NUM_KEYWORDS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_KEYWORDS-1:0] kws_out,
    input  logic                    kws_valid,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [KW_W-1:0]         evt_keyword,
    output logic [TS_BITS-1:0]      evt_timestamp,
    output logic                    overflow,
    input  logic                    clr_overflow
);

    localparam int SW = $clog2(CONFIRM_COUNT + 1);
    localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    // state     | meaning
    // S_IDLE    | detections are evaluated and may confirm an event
    // S_HOLDOFF | detections ignored until the holdoff counter expires
    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_HOLDOFF = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [TS_BITS-1:0] ts_q;
    logic [SW-1:0]     streak_q, streak_d;
    logic [KW_W-1:0]   cand_q, cand_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              overflow_q;
    logic [KW_W-1:0]   mem_kw_q [FIFO_DEPTH];
    logic [TS_BITS-1:0] mem_ts_q [FIFO_DEPTH];

    logic              onehot;
    logic [KW_W-1:0]   hit_idx;
    logic              push, pop, full, empty, wr_en, drop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        onehot  = (kws_out != '0) && ((kws_out & (kws_out - NUM_KEYWORDS'(1))) == '0);
        hit_idx = '0;
        for (int i = 0; i < NUM_KEYWORDS; i++) begin
            if (kws_out[i]) hit_idx = KW_W'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        cand_d   = cand_q;
        hold_d   = hold_q;
        push     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (kws_valid) begin
                    if (!onehot) begin
                        streak_d = '0;
                    end else if (hit_idx == cand_q) begin
                        streak_d = (streak_q == SW'(CONFIRM_COUNT)) ? streak_q : streak_q + 1'b1;
                    end else begin
                        cand_d   = hit_idx;
                        streak_d = SW'(1);
                    end
                    if (streak_d == SW'(CONFIRM_COUNT)) begin
                        push     = 1'b1;
                        streak_d = '0;
                        if (HOLDOFF_CYCLES != 0) begin
                            state_d = S_HOLDOFF;
                            hold_d  = HW'(HOLDOFF_CYCLES);
                        end
                    end
                end
            end
            default: begin
                streak_d = '0;
                if (hold_q <= HW'(1)) state_d = S_IDLE;
                else                  hold_d  = hold_q - 1'b1;
            end
        endcase
    end

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !empty && evt_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ts_q       <= '0;
            streak_q   <= '0;
            cand_q     <= '0;
            hold_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ts_q     <= ts_q + 1'b1;
            streak_q <= streak_d;
            cand_q   <= cand_d;
            hold_q   <= hold_d;
            if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // a drop in the same cycle as a clear request keeps the flag set
            if (drop)              overflow_q <= 1'b1;
            else if (clr_overflow) overflow_q <= 1'b0;
        end
    end

    // Storage needs no reset: the occupancy count gates what is visible.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_kw_q[wr_ptr_q] <= cand_d;
            mem_ts_q[wr_ptr_q] <= ts_q;
        end
    end

    assign evt_valid     = !empty;
    assign evt_keyword   = empty ? '0 : mem_kw_q[rd_ptr_q];
    assign evt_timestamp = empty ? '0 : mem_ts_q[rd_ptr_q];
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_kws_event_reporter.sv
// Directed bench for kws_event_reporter: a time-based event model is compared
// every cycle, plus literal expectations for each scenario.
module tb_kws_event_reporter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] kws_out = '0;
    logic       kws_valid = 1'b0;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [3:0] evt_keyword;
    logic [15:0] evt_timestamp;
    logic       overflow;
    logic       clr_overflow = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    int m_kw[$];
    int m_ts[$];
    int m_cand, m_streak, m_cyc, m_hold_end, m_sz, m_idx;
    bit m_ovf, m_pop, m_evt;
    int m_ek, m_et;

    int got_kw[$];
    int got_ts[$];

    kws_event_reporter #(
        .NUM_KEYWORDS(10), .CONFIRM_COUNT(3), .HOLDOFF_CYCLES(8),
        .TS_BITS(16), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .kws_out(kws_out), .kws_valid(kws_valid),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_keyword(evt_keyword),
        .evt_timestamp(evt_timestamp), .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_evt(input string name, input int i, input int kw, input int ts);
        if (i >= got_kw.size()) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: event %0d missing, got %0d events", name, i, got_kw.size());
        end else begin
            check({name, "_kw"}, got_kw[i], kw);
            check({name, "_ts"}, got_ts[i], ts);
        end
    endtask

    // Event model in absolute time: a confirmation at cycle c blocks evaluation through c+8.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_kw.delete(); m_ts.delete();
                m_cand = 0; m_streak = 0; m_cyc = 0; m_hold_end = -1; m_ovf = 0;
            end else begin
                m_sz  = m_kw.size();
                m_pop = (m_sz > 0) && evt_ready;
                m_evt = 1'b0;
                if (kws_valid && m_cyc > m_hold_end) begin
                    if ($countones(kws_out) == 1) begin
                        m_idx = 0;
                        for (int i = 0; i < 10; i++) if (kws_out[i]) m_idx = i;
                        if (m_idx == m_cand) m_streak = (m_streak < 3) ? m_streak + 1 : 3;
                        else begin m_cand = m_idx; m_streak = 1; end
                    end else begin
                        m_streak = 0;
                    end
                    if (m_streak == 3) begin
                        m_evt = 1'b1; m_ek = m_cand; m_et = m_cyc % 65536;
                        m_streak = 0; m_hold_end = m_cyc + 8;
                    end
                end
                if (m_pop) begin
                    void'(m_kw.pop_front());
                    void'(m_ts.pop_front());
                end
                if (m_evt && m_sz == 4 && !m_pop) m_ovf = 1'b1;
                else begin
                    if (m_evt) begin m_kw.push_back(m_ek); m_ts.push_back(m_et); end
                    if (clr_overflow) m_ovf = 1'b0;
                end
                m_cyc++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("evt_valid", evt_valid, m_kw.size() > 0);
                if (m_kw.size() > 0) begin
                    check("evt_keyword", evt_keyword, m_kw[0]);
                    check("evt_timestamp", evt_timestamp, m_ts[0]);
                end
                check("overflow", overflow, m_ovf);
                if (!rst && evt_valid && evt_ready) begin
                    got_kw.push_back(evt_keyword);
                    got_ts.push_back(evt_timestamp);
                end
            end
        end
    end

    task automatic step(input bit v, input logic [9:0] k);
        kws_valid = v;
        kws_out   = k;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 10'h000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 10'h000);
        rst = 1'b0;
        got_kw.delete();
        got_ts.delete();
    endtask

    initial begin
        logic [9:0] k;
        int kws[5];
        kws = '{0, 3, 5, 7, 9};

        do_reset();
        chk_en = 1'b1;
        check("rst_evt_valid", evt_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_keyword", evt_keyword, 0);
        check("rst_timestamp", evt_timestamp, 0);

        // detections at timestamps 10, 12, 14 with gaps
        evt_ready = 1'b1;
        idle(10);
        step(1'b1, 10'h004); idle(1);
        step(1'b1, 10'h004); idle(1);
        step(1'b1, 10'h004);
        check("t1_valid", evt_valid, 1);
        check("t1_kw", evt_keyword, 2);
        check("t1_ts", evt_timestamp, 14);
        idle(12);
        check("t1_count", got_kw.size(), 1);

        // candidate change restarts the streak
        do_reset();
        step(1'b1, 10'h004); step(1'b1, 10'h004);
        step(1'b1, 10'h010); step(1'b1, 10'h010); step(1'b1, 10'h010);
        idle(12);
        check("t2_count", got_kw.size(), 1);
        check_evt("t2_evt", 0, 4, 4);

        // multi-hot clears the streak
        do_reset();
        step(1'b1, 10'h004); step(1'b1, 10'h006);
        step(1'b1, 10'h004); step(1'b1, 10'h004);
        check("t3_no_evt", evt_valid, 0);
        step(1'b1, 10'h004);
        check("t3_valid", evt_valid, 1);
        check("t3_kw", evt_keyword, 2);
        check("t3_ts", evt_timestamp, 4);

        // holdoff window: confirm at 2, next confirm stamped 13
        do_reset();
        for (int i = 0; i < 14; i++) step(1'b1, 10'h002);
        idle(3);
        check("t4_count", got_kw.size(), 2);
        check_evt("t4_evt0", 0, 1, 2);
        check_evt("t4_evt1", 1, 1, 13);

        // overflow: five events into a four-deep queue with no reader
        do_reset();
        evt_ready = 1'b0;
        for (int e = 0; e < 5; e++) begin
            k = 10'(1) << kws[e];
            step(1'b1, k); step(1'b1, k); step(1'b1, k);
            idle(8);
        end
        check("t5_valid", evt_valid, 1);
        check("t5_overflow", overflow, 1);
        evt_ready = 1'b1;
        idle(6);
        evt_ready = 1'b0;
        check("t5_count", got_kw.size(), 4);
        check_evt("t5_evt0", 0, 0, 2);
        check_evt("t5_evt1", 1, 3, 13);
        check_evt("t5_evt2", 2, 5, 24);
        check_evt("t5_evt3", 3, 7, 35);
        check("t5_ovf_sticky", overflow, 1);
        clr_overflow = 1'b1;
        step(1'b0, 10'h000);
        clr_overflow = 1'b0;
        check("t5_ovf_clr", overflow, 0);

        // reset during holdoff with two events queued
        do_reset();
        evt_ready = 1'b0;
        step(1'b1, 10'h002); step(1'b1, 10'h002); step(1'b1, 10'h002);
        idle(8);
        step(1'b1, 10'h040); step(1'b1, 10'h040); step(1'b1, 10'h040);
        idle(2);
        check("t6_queued", evt_valid, 1);
        do_reset();
        check("t6_rst_valid", evt_valid, 0);
        check("t6_rst_ovf", overflow, 0);
        evt_ready = 1'b1;
        step(1'b1, 10'h008); step(1'b1, 10'h008); step(1'b1, 10'h008);
        check("t6_valid", evt_valid, 1);
        check("t6_kw", evt_keyword, 3);
        check("t6_ts", evt_timestamp, 2);
        idle(3);
        check("t6_count", got_kw.size(), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/kws_event_reporter.md
KWS_EVENT_REPORTER -- requirements
Module: kws_event_reporter

Interface
REQ-001 SHALL have parameter NUM_KEYWORDS, default 10: width of the kws_out detection vector.
REQ-002 SHALL have parameter CONFIRM_COUNT, default 3: consecutive identical detections required per event; legal range >= 1.
REQ-003 SHALL have parameter HOLDOFF_CYCLES, default 1024: ignore window after an event; 0 disables it.
REQ-004 SHALL have parameter TS_BITS, default 16: timestamp width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: event queue depth, power of two.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port kws_out, input, NUM_KEYWORDS bits: per-keyword detection vector from the KWS accelerator.
REQ-009 SHALL have port kws_valid, input, 1 bit: kws_out is valid this cycle; there is no backpressure toward the accelerator.
REQ-010 SHALL have port evt_valid, output, 1 bit: an event is presented at the queue head.
REQ-011 SHALL have port evt_ready, input, 1 bit: the host accepts the head event.
REQ-012 SHALL have port evt_keyword, output, clog2(NUM_KEYWORDS) bits: index of the detected keyword.
REQ-013 SHALL have port evt_timestamp, output, TS_BITS bits: timestamp of the confirming detection.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag, an event was dropped.
REQ-015 SHALL have port clr_overflow, input, 1 bit: clears overflow.

Function
REQ-016 SHALL run a free-running timestamp counter: +1 every cycle, wraps from 2^TS_BITS-1 to 0.
REQ-017 On a kws_valid cycle where kws_out has exactly one bit set, the candidate SHALL be that bit's index.
- Zero bits set, or more than one bit set: the result is invalid and SHALL clear the streak count to 0.
REQ-018 Valid candidate equal to the stored candidate SHALL increment the streak (saturating at CONFIRM_COUNT).
- Otherwise SHALL store the new candidate and set the streak to 1.
- Cycles with kws_valid=0 SHALL leave candidate and streak unchanged.
REQ-019 The FSM SHALL have exactly two states, IDLE and HOLDOFF.
- In IDLE, when the streak reaches CONFIRM_COUNT at kws_valid cycle t, SHALL push {candidate, timestamp at cycle t} into the FIFO.
- SHALL clear the streak.
- SHALL enter HOLDOFF at t+1, unless HOLDOFF_CYCLES=0, in which case it stays in IDLE.
REQ-020 In HOLDOFF, kws_valid results in cycles t+1 .. t+HOLDOFF_CYCLES SHALL be ignored and SHALL hold the streak at 0.
- The FSM SHALL return to IDLE so that a kws_valid at t+HOLDOFF_CYCLES+1 is evaluated normally.
REQ-021 The FIFO SHALL be first-word-fall-through.
- evt_valid = not empty.
- evt_keyword/evt_timestamp SHALL show the head entry and be stable while evt_valid=1 and evt_ready=0.
- A pop occurs when evt_valid and evt_ready are both 1.
REQ-022 Latency: a push at cycle t into an empty FIFO SHALL produce evt_valid=1 at t+1.
REQ-023 Push when full with no pop SHALL drop the new event, leave FIFO contents unchanged, and set overflow.
- Push and pop in the same cycle when full SHALL both succeed, with no overflow.
REQ-024 Push and pop in the same cycle when empty SHALL result in a pushed entry visible at t+1; there is no bypass.
REQ-025 evt_ready while empty SHALL have no effect.
REQ-026 clr_overflow SHALL clear overflow next cycle; if a drop occurs in the same cycle, set SHALL win.
REQ-027 The streak counter SHALL be clog2(CONFIRM_COUNT+1) bits wide; the holdoff counter SHALL be clog2(HOLDOFF_CYCLES+1) bits wide.
- No arithmetic overflow SHALL occur in either counter.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL reset:
- timestamp=0, streak=0, candidate=0, FSM=IDLE;
- FIFO empty, evt_valid=0, evt_keyword=0, evt_timestamp=0, overflow=0.
REQ-029 Reset mid-holdoff or with a non-empty FIFO SHALL discard all queued events and state with no partial output.
- The first cycle after rst deasserts SHALL behave as IDLE with an empty FIFO.

Verification (CONFIRM_COUNT=3, HOLDOFF_CYCLES=8, FIFO_DEPTH=4, TS_BITS=16)
REQ-030 The bench SHALL drive kws_out=0x004 with kws_valid at timestamps 10, 12, 14, evt_ready=1, and check:
- evt_valid=1 at the cycle after timestamp 14, with evt_keyword=2 and evt_timestamp=14;
- exactly one event.
REQ-031 The bench SHALL drive 0x004, 0x004, 0x010, 0x010, 0x010 on consecutive valid cycles and check:
- exactly one event, keyword=4, stamped at the fifth valid cycle.
REQ-032 The bench SHALL drive 0x004, 0x006 (multi-hot), 0x004, 0x004 and check:
- no event after the fourth cycle;
- a fifth 0x004 produces the event.
REQ-033 The bench SHALL confirm keyword 1 at cycle t, then hold kws_out=0x002 with kws_valid every cycle, and check:
- no event from results at t+1..t+8;
- the next event is stamped t+11, from confirmations at t+9, t+10, t+11.
REQ-034 The bench SHALL hold evt_ready=0 and generate 5 events, then check:
- evt_valid=1 and overflow=1;
- draining yields exactly the first 4 events in order;
- clr_overflow pulse drives overflow to 0 next cycle.
REQ-035 The bench SHALL assert rst for 1 cycle with 2 events queued during HOLDOFF and check:
- evt_valid=0 and timestamp=0 next cycle;
- a fresh 3-detection sequence is reported immediately, with no holdoff.
